// File: rtl/scrambler_pkg.sv
// Shared constants and types for the x^7+x^4+1 serial scrambler.
package scrambler_pkg;

    localparam int unsigned LFSR_W = 7;
    localparam int unsigned TAP_HI = 6;
    localparam int unsigned TAP_LO = 3;

    localparam logic [LFSR_W-1:0] SEED_ZERO_SUB_DEF = 7'b1111111;

    typedef enum logic {
        StLoad,
        StRun
    } state_e;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

endpackage

// File: rtl/scrambler_lfsr.sv
// Seedable 7-bit Fibonacci LFSR for S(x)=x^7+x^4+1.
// SCRAMBLER_SEQ_OUT_EN exposes the register contents on lfsr_o.
module scrambler_lfsr
    import scrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_ZERO_SUB = SEED_ZERO_SUB_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              fb_o
`ifdef SCRAMBLER_SEQ_OUT_EN
    ,
    output logic [LFSR_W-1:0] lfsr_o
`endif
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    assign fb_o = lfsr_fb(lfsr_q);

    // An all-zero seed would lock the LFSR, so it is replaced.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? SEED_ZERO_SUB : seed_i;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb_o};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

`ifdef SCRAMBLER_SEQ_OUT_EN
    assign lfsr_o = lfsr_q;
`endif

endmodule

// File: rtl/scrambler.sv
// Serial additive scrambler/descrambler: LOAD/RUN control, handshake and output registers.
// SCRAMBLER_SEQ_OUT_EN adds the scrambled_seq port showing the LFSR state.
module scrambler
    import scrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_ZERO_SUB = SEED_ZERO_SUB_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x,
    input  logic [LFSR_W-1:0] initialState,
    input  logic              run,
    output logic              x_scrambled,
    output logic              valid,
    output logic              rdy
`ifdef SCRAMBLER_SEQ_OUT_EN
    ,
    output logic [LFSR_W-1:0] scrambled_seq
`endif
);

    state_e state_q, state_d;
    logic   rdy_q, rdy_d;
    logic   valid_q, valid_d;
    logic   xs_q, xs_d;
    logic   fb;
    logic   accept;
    logic   load;

    // rdy_q is only ever set in RUN, so it alone qualifies the strobe.
    assign accept = run & rdy_q;
    assign load   = (state_q == StLoad);

    scrambler_lfsr #(
        .SEED_ZERO_SUB (SEED_ZERO_SUB)
    ) u_lfsr (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (load),
        .step_i (accept),
        .seed_i (initialState),
        .fb_o   (fb)
`ifdef SCRAMBLER_SEQ_OUT_EN
        ,
        .lfsr_o (scrambled_seq)
`endif
    );

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        valid_d = 1'b0;
        xs_d    = xs_q;
        unique case (state_q)
            StLoad: begin
                state_d = StRun;
                rdy_d   = 1'b1;
            end
            StRun: begin
                rdy_d = 1'b1;
                if (accept) begin
                    xs_d    = x ^ fb;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StLoad;
                rdy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            xs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            valid_q <= valid_d;
            xs_q    <= xs_d;
        end
    end

    assign x_scrambled = xs_q;
    assign valid       = valid_q;
    assign rdy         = rdy_q;

endmodule

// File: tb/tb_scrambler.sv
// Bench for scrambler: a scrambler chained into a descrambler, checked against a reference LFSR.
module tb_scrambler;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic       run;
    logic [6:0] initialState;
    logic       s_x_scr, s_valid, s_rdy;
    logic       d_x_scr, d_valid, d_rdy;
`ifdef SCRAMBLER_SEQ_OUT_EN
    logic [6:0] s_seq, d_seq;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [6:0] m_lfsr;
    logic       m_rdy;
    logic       m_load;

    logic exp_q[$];
    logic orig_q[$];
    logic out_log[$];
    logic exp_log[$];

    always #5 clk = ~clk;

    scrambler u_scr (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .initialState (initialState),
        .run          (run),
        .x_scrambled  (s_x_scr),
        .valid        (s_valid),
        .rdy          (s_rdy)
`ifdef SCRAMBLER_SEQ_OUT_EN
        ,
        .scrambled_seq (s_seq)
`endif
    );

    scrambler u_descr (
        .clk          (clk),
        .reset        (reset),
        .x            (s_x_scr),
        .initialState (initialState),
        .run          (s_valid),
        .x_scrambled  (d_x_scr),
        .valid        (d_valid),
        .rdy          (d_rdy)
`ifdef SCRAMBLER_SEQ_OUT_EN
        ,
        .scrambled_seq (d_seq)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Descrambled stream must reproduce the accepted input bits in order.
    always @(negedge clk) begin
        if (d_valid === 1'b1) begin
            if (orig_q.size() == 0) begin
                check_eq("descr_unexpected", 32'(d_valid), 32'd0);
            end else begin
                check_eq("descr", 32'(d_x_scr), 32'(orig_q.pop_front()));
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic cycle(input logic xi, input logic runi);
        logic acc, fb, e;
        x   = xi;
        run = runi;
        acc = runi & m_rdy;
        e   = 1'b0;
        if (m_load) begin
            m_lfsr = (initialState == 7'd0) ? 7'b1111111 : initialState;
            m_load = 1'b0;
        end else if (acc) begin
            fb     = m_lfsr[6] ^ m_lfsr[3];
            e      = xi ^ fb;
            exp_q.push_back(e);
            exp_log.push_back(e);
            orig_q.push_back(xi);
            m_lfsr = {m_lfsr[5:0], fb};
        end
        @(posedge clk);
        m_rdy = 1'b1;
        @(negedge clk);
        check_eq("rdy", 32'(s_rdy), 32'(m_rdy));
        check_eq("valid", 32'(s_valid), 32'(acc));
`ifdef SCRAMBLER_SEQ_OUT_EN
        check_eq("seq", 32'(s_seq), 32'(m_lfsr));
`endif
        if (acc) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check_eq("xs", 32'(s_x_scr), 32'(e));
            out_log.push_back(s_x_scr);
        end
    endtask

    // Asserted between clock edges so the clear is seen to be asynchronous.
    task automatic apply_reset(input logic [6:0] seed);
        #2;
        initialState = seed;
        reset = 1'b1;
        #1;
        check_eq("rst_xs", 32'(s_x_scr), 32'd0);
        check_eq("rst_valid", 32'(s_valid), 32'd0);
        check_eq("rst_rdy", 32'(s_rdy), 32'd0);
        check_eq("rst_dvalid", 32'(d_valid), 32'd0);
`ifdef SCRAMBLER_SEQ_OUT_EN
        check_eq("rst_seq", 32'(s_seq), 32'd0);
`endif
        exp_q.delete();
        orig_q.delete();
        m_lfsr = '0;
        m_rdy  = 1'b0;
        m_load = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_golden(input string tag);
        logic [15:0] gold;
        gold = 16'b0000_1110_1111_0010;
        out_log.delete();
        for (int i = 0; i < 40 && out_log.size() < 16; i++) cycle(1'b0, 1'b1);
        check_eq({tag, "_len"}, 32'(out_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < out_log.size(); i++) begin
            check_eq(tag, 32'(out_log[i]), 32'(gold[15-i]));
        end
    endtask

    initial begin
        int unsigned per_err;
        reset        = 1'b1;
        x            = 1'b0;
        run          = 1'b0;
        initialState = 7'b1111111;
        m_lfsr       = '0;
        m_rdy        = 1'b0;
        m_load       = 1'b1;
        @(negedge clk);

        // Known first 16 bits, then the zero-seed substitute gives the same.
        apply_reset(7'b1111111);
        run_golden("gold_ff");
        apply_reset(7'b0000000);
        run_golden("gold_zero");

        // Period 127 over 254 bits of zero input.
        apply_reset(7'b1111111);
        out_log.delete();
        exp_log.delete();
        for (int i = 0; i < 255 && out_log.size() < 254; i++) cycle(1'b0, 1'b1);
        check_eq("period_len", 32'(out_log.size()), 32'd254);
        per_err = 0;
        for (int i = 0; i < 127 && out_log.size() == 254; i++) begin
            if (out_log[i+127] !== exp_log[i]) per_err++;
        end
        check_eq("period", per_err, 32'd0);

        // Random data through the chain, then sparse strobes with seed churn in RUN.
        apply_reset(7'b1000011);
        for (int i = 0; i < 1000; i++) cycle(1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 200; i++) begin
            initialState = 7'($urandom);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Strobe held during LOAD, then toggled.
        initialState = 7'b0110101;
        run = 1'b1;
        apply_reset(7'b0110101);
        for (int i = 0; i < 24; i++) cycle(1'($urandom_range(0, 1)), 1'(i % 2 == 0));

        // Mid-stream reset after 20 bits restarts the sequence.
        apply_reset(7'b1111111);
        for (int i = 0; i < 21; i++) cycle(1'($urandom_range(0, 1)), 1'b1);
        apply_reset(7'b1111111);
        run_golden("gold_rst");

        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check_eq("drain", 32'(orig_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
